// File: rtl/multiplier_pipe_stream.sv
// Pipelined multiplier with valid/ready streams on both sides, per-op
// signed/unsigned mode and a sideband tag. Stalled stages hold their
// contents and bubbles collapse toward the output.
module multiplier_pipe_stream #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 6,
    parameter int DELAY   = 5,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    input  logic                       in_signed,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       busy
);

    localparam int PW = WIDTH_A + WIDTH_B;

    logic [DELAY-1:0] valid;
    logic [DELAY-1:0] adv;
    logic [PW-1:0]    prod [DELAY];
    logic [TAG_W-1:0] tag  [DELAY];

    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    logic [PW-1:0] product;
    logic          accept;

    // Extend operands to full product width; the low PW bits of the
    // extended product are exact for both signed and unsigned modes.
    always_comb begin
        ext_a   = in_signed ? {{(PW-WIDTH_A){in_a[WIDTH_A-1]}}, in_a}
                            : {{(PW-WIDTH_A){1'b0}}, in_a};
        ext_b   = in_signed ? {{(PW-WIDTH_B){in_b[WIDTH_B-1]}}, in_b}
                            : {{(PW-WIDTH_B){1'b0}}, in_b};
        product = ext_a * ext_b;
    end

    // Advance chain from the output back toward stage 0.
    always_comb begin
        logic    a;
        int unsigned k;
        adv          = '0;
        a            = out_ready;
        adv[DELAY-1] = a;
        for (int unsigned i = 0; i < DELAY - 1; i++) begin
            k      = DELAY - 2 - i;
            a      = !valid[k+1] || a;
            adv[k] = a;
        end
    end

    assign in_ready  = !valid[0] || adv[0];
    assign accept    = in_valid && in_ready;
    assign out_valid = valid[DELAY-1];
    assign out_data  = prod[DELAY-1];
    assign out_tag   = tag[DELAY-1];
    assign busy      = |valid;

    // Stage k takes stage k-1 whenever k-1 advances (stage k is then
    // either empty or moving on itself), which collapses bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int unsigned k = 0; k < DELAY; k++) begin
                prod[k] <= '0;
                tag[k]  <= '0;
            end
        end else begin
            if (in_ready) begin
                valid[0] <= accept;
                if (accept) begin
                    prod[0] <= product;
                    tag[0]  <= in_tag;
                end
            end
            for (int unsigned k = 1; k < DELAY; k++) begin
                if (adv[k-1]) begin
                    valid[k] <= valid[k-1];
                    if (valid[k-1]) begin
                        prod[k] <= prod[k-1];
                        tag[k]  <= tag[k-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplier_pipe_stream.sv
// Directed, table-driven bench for multiplier_pipe_stream with an
// in-order scoreboard keyed by vector index.
module tb_multiplier_pipe_stream;

    localparam int WA = 4;
    localparam int WB = 6;
    localparam int D  = 5;
    localparam int TW = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [WA-1:0]  in_a;
    logic [WB-1:0]  in_b;
    logic           in_signed;
    logic [TW-1:0]  in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [WA+WB-1:0] out_data;
    logic [TW-1:0]  out_tag;
    logic           busy;

    multiplier_pipe_stream #(
        .WIDTH_A(WA),
        .WIDTH_B(WB),
        .DELAY(D),
        .TAG_W(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_signed(in_signed),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tag(out_tag),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WA-1:0]    a;
        logic [WB-1:0]    b;
        logic             sgn;
        logic [TW-1:0]    tag;
        logic [WA+WB-1:0] exp;
    } vec_t;

    typedef struct {
        int idx;
        int cyc;
    } ent_t;

    vec_t vt [10];
    ent_t q [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_out    = 0;
    int cur_idx  = 0;
    bit lat_chk  = 1'b0;

    bit               prev_stall = 1'b0;
    logic [WA+WB-1:0] prev_data;
    logic [TW-1:0]    prev_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: handshakes are decided on the negedge before the edge.
    always @(negedge clk) begin
        ent_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {22'd0, out_data}, {22'd0, prev_data});
                chk("hold_tag", {28'd0, out_tag}, {28'd0, prev_tag});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", {22'd0, out_data}, {22'd0, vt[e.idx].exp});
                    chk("out_tag", {28'd0, out_tag}, {28'd0, vt[e.idx].tag});
                    if (lat_chk) chk("latency", cyc - e.cyc, D);
                end
            end
            if (in_valid && in_ready) begin
                e.idx = cur_idx;
                e.cyc = cyc;
                q.push_back(e);
                n_acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
    end

    // Called just after a posedge; returns just after the accept posedge.
    task automatic send(input int idx, output int waited);
        cur_idx   = idx;
        in_a      = vt[idx].a;
        in_b      = vt[idx].b;
        in_signed = vt[idx].sgn;
        in_tag    = vt[idx].tag;
        in_valid  = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || busy) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", {31'd0, (q.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        //           a      b      sgn   tag    exp
        vt[0] = '{4'hF, 6'h3F, 1'b0, 4'h3, 10'h3B1}; // 15*63 = 945
        vt[1] = '{4'h8, 6'h20, 1'b1, 4'h5, 10'h100}; // -8*-32 = 256
        vt[2] = '{4'h7, 6'h20, 1'b1, 4'h6, 10'h320}; // 7*-32 = -224
        vt[3] = '{4'h7, 6'h20, 1'b0, 4'h7, 10'h0E0}; // 7*32 = 224
        vt[4] = '{4'hF, 6'h3F, 1'b1, 4'h9, 10'h001}; // -1*-1 = 1
        vt[5] = '{4'h8, 6'h1F, 1'b1, 4'hA, 10'h308}; // -8*31 = -248
        vt[6] = '{4'h0, 6'h3F, 1'b0, 4'hB, 10'h000}; // 0*63
        vt[7] = '{4'h8, 6'h3F, 1'b0, 4'hC, 10'h1F8}; // 8*63 = 504
        vt[8] = '{4'h7, 6'h1F, 1'b1, 4'hD, 10'h0D9}; // 7*31 = 217
        vt[9] = '{4'hF, 6'h01, 1'b1, 4'hE, 10'h3FF}; // -1*1 = -1

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        idle(2);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", {22'd0, out_data}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Single ops: latency, unsigned/signed arithmetic, tags
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(i, w);
            chk("single_wait", w, 0);
            drain();
        end

        // Back-to-back streaming
        base = n_out;
        for (int i = 0; i < 20; i++) begin
            send(i % 10, w);
            chk("stream_in_ready", w, 0);
        end
        drain();
        chk("stream_count", n_out - base, 20);

        // Backpressure: fill, block, then release with simultaneous transfer
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        n_acc     = 0;
        base      = n_out;
        for (int i = 0; i < 5; i++) begin
            send(i, w);
            chk("bp_fill_wait", w, 0);
        end
        cur_idx   = 5;
        in_a      = vt[5].a;
        in_b      = vt[5].b;
        in_signed = vt[5].sgn;
        in_tag    = vt[5].tag;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_full_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", n_acc, 5);
        out_ready = 1'b1;
        send(5, w);
        chk("bp_simul_wait", w, 0);
        send(6, w);
        send(7, w);
        drain();
        chk("bp_total_acc", n_acc, 8);
        chk("bp_total_out", n_out - base, 8);

        // Bubble collapse: stalled head, gapped arrivals
        out_ready = 1'b0;
        n_acc     = 0;
        send(0, w);
        for (int j = 1; j < 5; j++) begin
            idle(2);
            chk("bub_busy", {31'd0, busy}, 32'd1);
            send(j, w);
            chk("bub_wait", w, 0);
        end
        @(negedge clk);
        chk("bub_full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bub_full_busy", {31'd0, busy}, 32'd1);
        chk("bub_accepted", n_acc, 5);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset mid-stream
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) send(i, w);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = n_out;
        idle(10);
        chk("no_stale_out", n_out - base, 0);
        send(0, w);
        drain();
        chk("post_rst_out", n_out - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
